// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes and the direction -> (dx,dy) helper
// used by the movement stage, the direction filter and the renderer.
package snake_pkg;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_D = 2'b01;
    localparam logic [1:0] DIR_L = 2'b10;
    localparam logic [1:0] DIR_U = 2'b11;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input logic [1:0] d);
        delta_t r;
        r.dx = 2'sd0;
        r.dy = 2'sd0;
        case (d)
            DIR_R:   r.dx =  2'sd1;
            DIR_D:   r.dy =  2'sd1;
            DIR_L:   r.dx = -2'sd1;
            default: r.dy = -2'sd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_if.sv
// Bundle between the snake movement stage and its neighbours (direction filter,
// renderer). The slave side is the movement stage.
interface snake_if #(
    parameter int XW  = 3,
    parameter int YW  = 3,
    parameter int LEN = 4
);
    logic                en;
    logic [1:0]          next_dir;
    logic [1:0]          dir;
    logic [LEN*XW-1:0]   seg_x;
    logic [LEN*YW-1:0]   seg_y;
    logic                step;
    logic                game_over;

    modport master (
        output en, next_dir,
        input  dir, seg_x, seg_y, step, game_over
    );

    modport slave (
        input  en, next_dir,
        output dir, seg_x, seg_y, step, game_over
    );
endinterface

// File: rtl/snake_tick_gen.sv
// Move pacing: counts 0..TICK_DIV-1 while running and flags the last count as the
// move cycle. Holding (en low or halted) freezes the count without restarting it.
module snake_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_halt,
    output logic o_move_cycle
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_run;
    logic          w_last;

    assign w_run  = i_en & ~i_halt;
    assign w_last = (r_cnt == CW'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_move_cycle = w_run & w_last;

endmodule

// File: rtl/snake_step.sv
// Snake movement stage: holds pending presses between ticks, advances the head with
// toroidal wrap on each move cycle, shifts the body and latches self-collision.
module snake_step
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int XW       = 3,
    parameter int YW       = 3,
    parameter int LEN      = 4
) (
    input  logic   clk,
    input  logic   rst,
    snake_if.slave io_bus
);
    logic [XW-1:0] r_seg_x [LEN];
    logic [YW-1:0] r_seg_y [LEN];
    logic [1:0]    r_dir;
    logic [1:0]    r_pend;
    logic          r_step;
    logic          r_go;

    logic          w_move;
    logic [1:0]    w_nd;
    delta_t        w_delta;
    logic [XW-1:0] w_dx;
    logic [YW-1:0] w_dy;
    logic [XW-1:0] w_head_x;
    logic [YW-1:0] w_head_y;
    logic          w_hit;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk          (clk),
        .rst          (rst),
        .i_en         (io_bus.en),
        .i_halt       (r_go),
        .o_move_cycle (w_move)
    );

    // A fresh press in the move cycle itself wins over the one held as pending.
    assign w_nd     = (io_bus.next_dir != r_dir) ? io_bus.next_dir : r_pend;
    assign w_delta  = dir_delta(w_nd);
    assign w_dx     = XW'({{XW{w_delta.dx[1]}}, w_delta.dx});
    assign w_dy     = YW'({{YW{w_delta.dy[1]}}, w_delta.dy});
    assign w_head_x = r_seg_x[0] + w_dx;
    assign w_head_y = r_seg_y[0] + w_dy;

    // NOTE: every always_comb output gets a default before any condition, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < LEN - 1; i++) begin
            if (r_seg_x[i] == w_head_x && r_seg_y[i] == w_head_y) begin
                w_hit = 1'b1;
            end
        end
    end

    // NOTE: the segment array is reset element by element because the starting
    // body is part of the game state, not don't-care storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir  <= DIR_R;
            r_pend <= DIR_R;
            r_step <= 1'b0;
            r_go   <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                r_seg_x[i] <= XW'(LEN - 1 - i);
                r_seg_y[i] <= '0;
            end
        end else begin
            r_step <= 1'b0;
            if (w_move) begin
                if (w_hit) begin
                    r_go <= 1'b1;
                end else begin
                    r_dir      <= w_nd;
                    r_pend     <= w_nd;
                    r_step     <= 1'b1;
                    r_seg_x[0] <= w_head_x;
                    r_seg_y[0] <= w_head_y;
                    for (int i = 1; i < LEN; i++) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                end
            end else if (!r_go && io_bus.next_dir != r_dir) begin
                r_pend <= io_bus.next_dir;
            end
        end
    end

    for (genvar g = 0; g < LEN; g++) begin : g_pack
        assign io_bus.seg_x[g*XW +: XW] = r_seg_x[g];
        assign io_bus.seg_y[g*YW +: YW] = r_seg_y[g];
    end

    assign io_bus.dir       = r_dir;
    assign io_bus.step      = r_step;
    assign io_bus.game_over = r_go;

endmodule
